// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_types_pkg
//  Description : Shared types for the pipeline controller: the sequencer state
//                encoding, register-field type and held-hit helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_types_pkg;

  // Width of an architectural register specifier.
  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  // Sequencer states. The *_DONE states remember a cache hit that has already
  // been consumed while the other side of the pipeline is still waiting.
  typedef enum logic [2:0] {
    RUN     = 3'd0,
    I_DONE  = 3'd1,
    D_DONE  = 3'd2,
    ID_DONE = 3'd3,
    HALTED  = 3'd4
  } pctrl_state_t;

  // True when the instruction fetch for the current slot is already satisfied.
  function automatic logic fetch_held(input pctrl_state_t s);
    return (s == I_DONE) || (s == ID_DONE);
  endfunction

  // True when the data access for the current slot is already satisfied.
  function automatic logic data_held(input pctrl_state_t s);
    return (s == D_DONE) || (s == ID_DONE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_detect
//  Description : Load-use hazard detection between the ID and EX stages.
//                Flags when the instruction in ID reads a register that the
//                load in EX has not yet produced. x0 never creates a hazard.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_detect
  import cpu_types_pkg::*;
(
  input  regbits_t rs1_id,
  input  regbits_t rs2_id,
  input  regbits_t rd_ex,
  input  logic     memtoreg_ex,
  output logic     lu
);

  logic rd_nonzero;
  logic src_match;

  // Compare the load destination against both ID-stage sources.
  always_comb begin
    rd_nonzero = (rd_ex != '0);
    src_match  = (rd_ex == rs1_id) || (rd_ex == rs2_id);
    lu         = memtoreg_ex & rd_nonzero & src_match;
  end

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Stall/flush sequencer for the 5-stage pipeline. Decides each
//                cycle whether the stage registers load, hold or load a
//                bubble, gates cache requests so a satisfied access is not
//                reissued, freezes on halt and counts stall cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_ctrl
  import cpu_types_pkg::*;
#(
  parameter int STALL_W = 16
) (
  input  logic               CLK,
  input  logic               nRST,
  // cache handshake
  input  logic               ihit,
  input  logic               dhit,
  input  logic               dmemREN_mem,
  input  logic               dmemWEN_mem,
  output logic               iREN_out,
  output logic               dREN_out,
  output logic               dWEN_out,
  // hazard sources
  input  regbits_t           rs1_id,
  input  regbits_t           rs2_id,
  input  regbits_t           rd_ex,
  input  logic               memtoreg_ex,
  input  logic               taken_ex,
  input  logic               halt_wb,
  // pipeline register control
  output logic               pc_en,
  output logic               en_ifid,
  output logic               en_idex,
  output logic               en_exmem,
  output logic               en_memwb,
  output logic               flush_ifid,
  output logic               flush_idex,
  output logic               halt,
  output logic [STALL_W-1:0] stall_cnt
);

  pctrl_state_t state;
  pctrl_state_t next_state;

  logic mem_op;
  logic i_ok;
  logic d_ok;
  logic adv;
  logic lu;
  logic got_d;
  logic halted;
  logic req_i_phase;
  logic req_d_phase;

  hazard_detect u_hazard (
    .rs1_id      (rs1_id),
    .rs2_id      (rs2_id),
    .rd_ex       (rd_ex),
    .memtoreg_ex (memtoreg_ex),
    .lu          (lu)
  );

  // State register; reset abandons any held hit so the access is reissued.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // Advance decision, next state, request gating and stage-register control.
  always_comb begin
    next_state  = state;
    halted      = (state == HALTED);
    mem_op      = dmemREN_mem | dmemWEN_mem;
    i_ok        = ihit | fetch_held(state);
    got_d       = (mem_op & dhit) | data_held(state);
    d_ok        = !mem_op | got_d;
    adv         = i_ok & d_ok & !halted;

    // A side may only request while its hit has not been captured yet.
    req_i_phase = (state == RUN) || (state == D_DONE);
    req_d_phase = (state == RUN) || (state == I_DONE);

    if (halted) begin
      next_state = HALTED;
    end else if (adv) begin
      next_state = halt_wb ? HALTED : RUN;
    end else begin
      // Remember whichever hits have been seen for the stalled slot.
      case ({i_ok, got_d})
        2'b11:   next_state = ID_DONE;
        2'b10:   next_state = I_DONE;
        2'b01:   next_state = D_DONE;
        default: next_state = RUN;
      endcase
    end

    iREN_out   = req_i_phase;
    dREN_out   = dmemREN_mem & req_d_phase;
    dWEN_out   = dmemWEN_mem & req_d_phase;

    // The back half always moves on an advance; the front holds for a
    // load-use bubble unless a taken branch redirects and squashes it anyway.
    en_exmem   = adv;
    en_memwb   = adv;
    en_idex    = adv;
    en_ifid    = adv & (!lu | taken_ex);
    pc_en      = adv & (!lu | taken_ex);
    flush_idex = adv & (lu | taken_ex);
    flush_ifid = adv & taken_ex;
  end

  // Sticky halt indication follows the registered state.
  always_comb begin
    halt = (state == HALTED);
  end

  // Saturating count of cycles where the running machine could not advance.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
    end else if (!halted && !adv && (stall_cnt != {STALL_W{1'b1}})) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

endmodule
`default_nettype wire
